// File: rtl/cmp_arb_pkg.sv
// Shared types and round-robin pick function for the comparator arbiter.
// The pick function is sized for up to MAX_REQ requesters; callers pass the live count.
package cmp_arb_pkg;

   localparam int unsigned CMP_W   = 3;
   localparam int unsigned MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      RSP
   } state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // Scan from ptr+n down to ptr+1 so the candidate closest after ptr is written last and wins.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                        input logic [2:0]         ptr,
                                        input int                 n);
      rr_pick_t   res;
      logic [2:0] cand;
      int         sum;
      res = '0;
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= n) begin
            sum  = (int'(ptr) + k) % n;
            cand = sum[2:0];
            if (valid[cand]) begin
               res.found = 1'b1;
               res.idx   = cand;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/threebit.sv
// Unsigned 3-bit magnitude comparator; purely combinational.
module threebit (
   input  logic [2:0] a,
   input  logic [2:0] b,
   output logic       gt,
   output logic       eq,
   output logic       lt
);

   assign gt = (a > b);
   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one threebit comparator between N_REQ requesters,
// returning each result with its requester id on a valid/ready response channel.
module cmp_arbiter
   import cmp_arb_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [CMP_W*N_REQ-1:0] req_a,
   input  logic [CMP_W*N_REQ-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_gt,
   output logic                   rsp_eq,
   output logic                   rsp_lt,
   output logic                   busy
);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   id_q;
   logic [CMP_W-1:0]  op_a_q, op_b_q;
   logic              gt_q, eq_q, lt_q;

   logic [CMP_W-1:0]  a_arr [N_REQ];
   logic [CMP_W-1:0]  b_arr [N_REQ];
   logic [MAX_REQ-1:0] valid_ext;
   rr_pick_t          pick;
   logic [ID_W-1:0]   win_id;
   logic              grant;
   logic              cmp_gt, cmp_eq, cmp_lt;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         a_arr[i] = req_a[CMP_W*i +: CMP_W];
         b_arr[i] = req_b[CMP_W*i +: CMP_W];
      end
   end

   assign valid_ext = MAX_REQ'(req_valid);
   assign pick      = rr_pick(valid_ext, 3'(ptr_q), N_REQ);
   assign win_id    = pick.idx[ID_W-1:0];
   // Grant is masked by rst so every output reads zero while reset is held.
   assign grant     = (state_q == IDLE) && pick.found && !rst;

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               req_ready[win_id] = 1'b1;
               state_d           = CMP;
            end
         end
         CMP:     state_d = RSP;
         RSP:     if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q  <= ID_W'(N_REQ - 1);
         id_q   <= '0;
         op_a_q <= '0;
         op_b_q <= '0;
         gt_q   <= 1'b0;
         eq_q   <= 1'b0;
         lt_q   <= 1'b0;
      end else begin
         if (grant) begin
            op_a_q <= a_arr[win_id];
            op_b_q <= b_arr[win_id];
            id_q   <= win_id;
            ptr_q  <= win_id;
         end
         if (state_q == CMP) begin
            gt_q <= cmp_gt;
            eq_q <= cmp_eq;
            lt_q <= cmp_lt;
         end
      end
   end

   threebit u_threebit (
      .a  (op_a_q),
      .b  (op_b_q),
      .gt (cmp_gt),
      .eq (cmp_eq),
      .lt (cmp_lt)
   );

   assign rsp_valid = (state_q == RSP);
   assign rsp_id    = id_q;
   assign rsp_gt    = gt_q;
   assign rsp_eq    = eq_q;
   assign rsp_lt    = lt_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: reset, single, boundaries, contention, wrap, backpressure.
module tb_cmp_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [11:0] req_a = '0;
   logic [11:0] req_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;
   logic        rsp_gt, rsp_eq, rsp_lt;
   logic        busy;

   int   errors = 0;
   int   checks = 0;
   logic oh_bad = 1'b0;

   always #5 clk = ~clk;

   cmp_arbiter #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_gt    (rsp_gt),
      .rsp_eq    (rsp_eq),
      .rsp_lt    (rsp_lt),
      .busy      (busy)
   );

   task automatic set_op(input int idx, input logic [2:0] a, input logic [2:0] b);
      req_a[3*idx +: 3] = a;
      req_b[3*idx +: 3] = b;
   endtask

   // Called and returns just after a rising edge; drops the granted bit from req_valid.
   task automatic txn(output logic ok, output logic [1:0] id, output logic [2:0] res,
                      output int lat);
      logic [3:0] g;
      g   = '0;
      ok  = 1'b0;
      id  = '0;
      res = '0;
      lat = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!$onehot0(req_ready)) oh_bad = 1'b1;
         g = req_ready;
         @(posedge clk);
         #1;
         if (g != '0) begin
            req_valid = req_valid & ~g;
            break;
         end
      end
      if (g == '0) return;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         lat++;
         if (!$onehot0(req_ready)) oh_bad = 1'b1;
         if (rsp_valid) begin
            ok  = 1'b1;
            id  = rsp_id;
            res = {rsp_gt, rsp_eq, rsp_lt};
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      logic       seen, ok;
      logic [1:0] id;
      logic [2:0] res;
      int         lat;
      req_valid = 4'b1111;
      @(negedge clk);
      #1;
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_gt, rsp_eq, rsp_lt, rsp_id} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {req_ready, rsp_valid, busy, rsp_gt, rsp_eq, rsp_lt, rsp_id});
      end
      req_valid = '0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      rsp_ready = 1'b1;
      set_op(1, 3'd4, 3'd2);
      req_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL reset_grant1: got %b expected 0010", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_cmp: busy got %b expected 1", busy);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, rsp_valid, rsp_gt, rsp_eq, rsp_lt, req_ready} !== 9'd0) begin
         errors++;
         $display("FAIL reset_async: got %b expected 0",
                  {busy, rsp_valid, rsp_gt, rsp_eq, rsp_lt, req_ready});
      end
      @(posedge clk);
      #1;
      rst  = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_rsp: activity got %b expected 0", seen);
      end
      // Pointer back at 3, so among {1,2} requester 1 wins.
      req_valid = 4'b0110;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL reset_ptr: got %b expected 0010", req_ready);
      end
      req_valid = '0;
      @(posedge clk);
      #1;
      set_op(0, 3'd2, 3'd2);
      req_valid = 4'b0001;
      txn(ok, id, res, lat);
      checks++;
      if (!ok || id !== 2'd0 || res !== 3'b010) begin
         errors++;
         $display("FAIL reset_first_grant: got ok=%b id=%0d res=%b expected ok=1 id=0 res=010",
                  ok, id, res);
      end
   endtask

   task automatic test_single;
      logic       ok;
      logic [1:0] id;
      logic [2:0] res;
      int         lat;
      set_op(0, 3'd6, 3'd1);
      req_valid = 4'b0001;
      txn(ok, id, res, lat);
      checks++;
      if (ok !== 1'b1 || id !== 2'd0) begin
         errors++;
         $display("FAIL single_id: got ok=%b id=%0d expected ok=1 id=0", ok, id);
      end
      checks++;
      if (res !== 3'b100) begin
         errors++;
         $display("FAIL single_result: got %b expected 100", res);
      end
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL single_latency: got %0d expected 2", lat);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_boundaries;
      logic [2:0] va [4] = '{3'd7, 3'd0, 3'd7, 3'd0};
      logic [2:0] vb [4] = '{3'd0, 3'd7, 3'd7, 3'd0};
      logic [2:0] ve [4] = '{3'b100, 3'b001, 3'b010, 3'b010};
      logic       ok;
      logic [1:0] id;
      logic [2:0] res;
      int         lat;
      for (int k = 0; k < 4; k++) begin
         set_op(3, va[k], vb[k]);
         req_valid = 4'b1000;
         txn(ok, id, res, lat);
         checks++;
         if (!ok || id !== 2'd3 || res !== ve[k]) begin
            errors++;
            $display("FAIL boundary_%0d_%0d: got ok=%b id=%0d res=%b expected ok=1 id=3 res=%b",
                     va[k], vb[k], ok, id, res, ve[k]);
         end
      end
   endtask

   task automatic test_contention;
      logic [2:0] ve [4] = '{3'b100, 3'b001, 3'b100, 3'b010};
      logic       ok;
      logic [1:0] id;
      logic [2:0] res;
      int         lat;
      set_op(0, 3'd6, 3'd1);
      set_op(1, 3'd2, 3'd3);
      set_op(2, 3'd5, 3'd4);
      set_op(3, 3'd3, 3'd3);
      oh_bad    = 1'b0;
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         txn(ok, id, res, lat);
         checks++;
         if (!ok || id !== 2'(k) || res !== ve[k]) begin
            errors++;
            $display("FAIL contention_%0d: got ok=%b id=%0d res=%b expected ok=1 id=%0d res=%b",
                     k, ok, id, res, k, ve[k]);
         end
      end
      checks++;
      if (oh_bad !== 1'b0) begin
         errors++;
         $display("FAIL contention_onehot: req_ready not one-hot-or-zero in some cycle");
      end
   endtask

   task automatic test_wrap;
      logic       ok;
      logic [1:0] id;
      logic [2:0] res;
      int         lat;
      req_valid = 4'b0101;
      txn(ok, id, res, lat);
      checks++;
      if (!ok || id !== 2'd0) begin
         errors++;
         $display("FAIL wrap_first: got ok=%b id=%0d expected ok=1 id=0", ok, id);
      end
      txn(ok, id, res, lat);
      checks++;
      if (!ok || id !== 2'd2 || res !== 3'b100) begin
         errors++;
         $display("FAIL wrap_second: got ok=%b id=%0d res=%b expected ok=1 id=2 res=100",
                  ok, id, res);
      end
   endtask

   task automatic test_back_pressure;
      logic       ok;
      logic [1:0] id;
      logic [2:0] res;
      int         lat;
      set_op(3, 3'd1, 3'd5);
      rsp_ready = 1'b0;
      req_valid = 4'b1010;
      txn(ok, id, res, lat);
      checks++;
      if (!ok || id !== 2'd3 || res !== 3'b001) begin
         errors++;
         $display("FAIL bp_first: got ok=%b id=%0d res=%b expected ok=1 id=3 res=001",
                  ok, id, res);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy, req_ready} !== 11'b1_11_001_1_0000)
         begin
            errors++;
            $display("FAIL bp_hold_%0d: got %b expected 11100110000", c,
                     {rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy, req_ready});
         end
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_release: got valid=%b busy=%b ready=%b expected 0 0 0010",
                  rsp_valid, busy, req_ready);
      end
      req_valid = '0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundaries();
      test_contention();
      test_wrap();
      test_back_pressure();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one `threebit` 3-bit magnitude comparator between N_REQ requesters.
- Arbitrates round-robin and sequences each compare through a 3-state FSM.
- Returns each result with the requester's id on a valid/ready response channel.
- Sits between operand producers and result consumers; the comparator instance stays purely combinational.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), derived localparam, width of requester id.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request strobe.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_a  in  3*N_REQ  packed operand A; requester i uses bits [3i+2:3i].
- req_b  in  3*N_REQ  packed operand B; same slicing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of the requester owning the result.
- rsp_gt  out  1  A > B (unsigned).
- rsp_eq  out  1  A == B.
- rsp_lt  out  1  A < B.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, rr pointer=N_REQ-1, op/id/result registers=0. All outputs 0. Any in-flight operation is discarded and produces no response.
- FSM states: IDLE, CMP, RSP.
- IDLE:
  - Winner = first i with req_valid[i] set, searching upward from (ptr+1) mod N_REQ with wrap.
  - req_ready[winner]=1, combinational from req_valid and ptr. All other req_ready bits are 0.
  - On the clk edge where req_valid[i] & req_ready[i]: latch req_a/req_b slice i into op_a/op_b, latch id=i, set ptr=i, go to CMP.
  - If no request is valid, stay in IDLE.
- CMP:
  - Comparator inputs are driven only from op_a/op_b.
  - On the next edge, register gt/eq/lt, then go to RSP.
- RSP:
  - rsp_valid=1.
  - rsp_id, rsp_gt, rsp_eq and rsp_lt are stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1, go to IDLE and drop rsp_valid. rsp_ready may already be high when RSP is entered.
- req_ready is all-zero in CMP and RSP. Requesters must hold req_valid and operands until accepted; a request dropped before acceptance is simply never served.
- Latency: accept edge E0 -> CMP. E0+1 -> RSP, so rsp_valid is high in the cycle after E0+1. With rsp_ready tied high, peak throughput is 1 compare per 3 cycles.
- Result invariant: while rsp_valid=1, exactly one of gt/eq/lt is 1. Outside RSP, result outputs hold their last registered value and consumers qualify them with rsp_valid.
- Fairness: with all requesters continuously valid, grant order is 0,1,...,N_REQ-1,0,... No requester waits more than N_REQ-1 grants.
- Arithmetic: unsigned 3-bit compare over the full range 0..7.
- busy = (state != IDLE).

Decomposition:
- Package cmp_arb_pkg holds:
  - typedef enum state_t {IDLE, CMP, RSP};
  - localparam CMP_W=3;
  - function rr_pick(valid, ptr), returning winner index and a found flag.
- Datapath reuses the existing `threebit` module unchanged as the single sub-module instance.
- No further sub-modules.

Test Plan:
1. Reset: assert rst mid-CMP of req 1 -> outputs 0 immediately, no rsp_valid afterwards. Next lone req 0 is granted first.
2. Single request: req_valid=0001, a=6, b=1, rsp_ready=1 -> rsp_valid after 2 edges from accept, rsp_id=0, gt=1, eq=0, lt=0.
3. Contention: all four valid:
   - req0 a=6 b=1; req1 a=2 b=3; req2 a=5 b=4; req3 a=3 b=3.
   - Required: responses in order id 0(gt), 1(lt), 2(gt), 3(eq).
   - req_ready one-hot or zero in every cycle.
4. Backpressure: rsp_ready=0 for 5 cycles in RSP -> rsp_valid/id/result stable, req_ready=0, busy=1. Raising rsp_ready returns FSM to IDLE on the next edge.
5. Wrap/fairness: after grant to 3, req_valid=0101 -> grant 0 then 2.
6. Boundaries: (7,0) gt; (0,7) lt; (7,7) eq; (0,0) eq -> one-hot result each time.
